// File: rtl/led_pwm_blinker.sv
// Red-LED output stage: applies a global PWM brightness and a per-LED blink mask to the PIO
// LED word. Configured through a 4-register Avalon-MM slave.
module led_pwm_blinker #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned PWM_DIV = 1,
  parameter int unsigned BLINK_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   led_in,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [WIDTH-1:0]   led_out
);

  localparam int unsigned PreW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PWM_DIV - 1);

  logic [1:0]         r_ctrl;
  logic [8:0]         r_duty;
  logic [BLINK_W-1:0] r_period;
  logic [WIDTH-1:0]   r_mask;

  logic [PreW-1:0]    r_pre;
  logic [7:0]         r_pwm_cnt;
  logic [8:0]         r_duty_act;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [WIDTH-1:0]   r_led_out;

  logic               w_wr;
  logic               w_pre_wrap;
  logic               w_pwm_wrap;
  logic               w_pwm_on;
  logic [8:0]         w_duty_wdata;
  logic               w_period_wr;
  logic [WIDTH-1:0]   w_pwm_gate;
  logic [WIDTH-1:0]   w_blink_kill;

  assign w_wr         = chipselect && !write_n;
  assign w_pre_wrap   = (r_pre == PreMax);
  assign w_pwm_wrap   = w_pre_wrap && (r_pwm_cnt == 8'hFF);
  assign w_pwm_on     = (r_duty_act > {1'b0, r_pwm_cnt});
  assign w_duty_wdata = (writedata > 32'd256) ? 9'd256 : writedata[8:0];
  assign w_period_wr  = w_wr && (address == 2'd2);
  assign w_pwm_gate   = r_ctrl[0] ? {WIDTH{w_pwm_on}} : {WIDTH{1'b1}};
  assign w_blink_kill = r_mask & {WIDTH{r_ctrl[1] & ~r_phase}};

  // Configuration registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl   <= '0;
      r_duty   <= 9'd256;
      r_period <= '0;
      r_mask   <= '0;
    end else if (w_wr) begin
      case (address)
        2'd0: r_ctrl   <= writedata[1:0];
        2'd1: r_duty   <= w_duty_wdata;
        2'd2: r_period <= writedata[BLINK_W-1:0];
        2'd3: r_mask   <= writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // PWM prescaler, counter and duty shadow (shadow reloads only at the period boundary)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pre      <= '0;
      r_pwm_cnt  <= '0;
      r_duty_act <= 9'd256;
    end else begin
      if (w_pre_wrap) begin
        r_pre     <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_pre     <= r_pre + 1'b1;
      end
      if (w_pwm_wrap) begin
        r_duty_act <= r_duty;
      end
    end
  end

  // Blink half-period counter; a PERIOD write restarts on an on-phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_period_wr || (r_period == '0)) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == r_period - 1'b1) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_led_out <= '0;
    end else begin
      r_led_out <= led_in & w_pwm_gate & ~w_blink_kill;
    end
  end

  assign led_out = r_led_out;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1:0]         = r_ctrl;
      2'd1: readdata[8:0]         = r_duty;
      2'd2: readdata[BLINK_W-1:0] = r_period;
      2'd3: readdata[WIDTH-1:0]   = r_mask;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Directed bench for led_pwm_blinker: reset, pass-through, PWM duty, glitch-free duty update,
// blink timing and mid-operation reset.
module tb_led_pwm_blinker;

  localparam int unsigned WIDTH = 18;
  localparam logic [WIDTH-1:0] AllOn = 18'h3FFFF;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] led_in;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] led_out;

  int n_tests;
  int n_fail;

  led_pwm_blinker #(
    .WIDTH  (WIDTH),
    .PWM_DIV(1),
    .BLINK_W(24)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .led_in    (led_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    check_eq(tag, readdata, exp);
  endtask

  task automatic count_on(input int n, output int on_cnt, output int bad_cnt);
    on_cnt  = 0;
    bad_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (led_out == AllOn) on_cnt++;
      else if (led_out != '0) bad_cnt++;
    end
  endtask

  // Sample k after a PERIOD=10 restart: 1..10 on, 11..20 off, ...
  task automatic blink_run(input string tag, input int n);
    logic [WIDTH-1:0] exp;
    int               errs;
    errs = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      exp = (((k - 1) / 10) % 2 == 0) ? AllOn : 18'h3FFFC;
      if (led_out !== exp) errs++;
    end
    check_eq(tag, errs, 0);
  endtask

  initial begin
    int on_cnt;
    int bad_cnt;
    int found;
    logic prev_on;

    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    led_in     = AllOn;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    repeat (3) tick();
    check_eq("reset_led_out", led_out, 0);
    read_check("reset_ctrl", 2'd0, 0);
    read_check("reset_duty", 2'd1, 256);
    read_check("reset_period", 2'd2, 0);
    read_check("reset_mask", 2'd3, 0);

    reset_n = 1'b1;
    led_in  = 18'h2A5A5;
    tick();
    check_eq("pass_a", led_out, 18'h2A5A5);
    led_in = 18'h15A5A;
    #1;
    check_eq("pass_latency", led_out, 18'h2A5A5);
    tick();
    check_eq("pass_b", led_out, 18'h15A5A);

    led_in = AllOn;
    bus_write(2'd1, 64);
    bus_write(2'd0, 1);
    repeat (300) tick();
    count_on(256, on_cnt, bad_cnt);
    check_eq("pwm64_on", on_cnt, 64);
    check_eq("pwm64_levels", bad_cnt, 0);

    bus_write(2'd1, 0);
    repeat (300) tick();
    count_on(256, on_cnt, bad_cnt);
    check_eq("pwm0_on", on_cnt, 0);

    bus_write(2'd1, 300);
    read_check("duty_sat_read", 2'd1, 256);
    repeat (300) tick();
    count_on(256, on_cnt, bad_cnt);
    check_eq("pwm256_on", on_cnt, 256);

    // Glitch-free update: locate a period start from the off->on edge of duty 64
    bus_write(2'd1, 64);
    repeat (300) tick();
    found   = 0;
    prev_on = 1'b1;
    for (int i = 0; i < 600 && found == 0; i++) begin
      tick();
      if (led_out == AllOn && !prev_on) found = 1;
      prev_on = (led_out == AllOn);
    end
    check_eq("pwm_rise_found", found, 1);
    if (found == 1) begin
      on_cnt = 1;
      for (int i = 1; i < 256; i++) begin
        if (i == 100) begin
          address    = 2'd1;
          writedata  = 128;
          chipselect = 1'b1;
          write_n    = 1'b0;
        end
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        if (i == 100) read_check("duty_read_immediate", 2'd1, 128);
        if (led_out == AllOn) on_cnt++;
      end
      check_eq("pwm_cur_period", on_cnt, 64);
      count_on(256, on_cnt, bad_cnt);
      check_eq("pwm_next_period", on_cnt, 128);
    end

    bus_write(2'd0, 2);
    bus_write(2'd3, 32'h3);
    bus_write(2'd2, 10);
    read_check("period_read", 2'd2, 10);
    blink_run("blink_first", 40);
    repeat (5) tick();
    bus_write(2'd2, 10);
    blink_run("blink_restart", 30);

    bus_write(2'd1, 128);
    bus_write(2'd0, 3);
    repeat (37) tick();
    reset_n = 1'b0;
    tick();
    check_eq("midreset_led_out", led_out, 0);
    reset_n = 1'b1;
    read_check("midreset_ctrl", 2'd0, 0);
    read_check("midreset_duty", 2'd1, 256);
    read_check("midreset_period", 2'd2, 0);
    read_check("midreset_mask", 2'd3, 0);
    led_in = 18'h2A5A5;
    tick();
    check_eq("midreset_pass", led_out, 18'h2A5A5);

    address    = 2'd0;
    writedata  = 3;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick();
    write_n = 1'b1;
    read_check("cs_low_ignored", 2'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_blinker.md
Name: led_pwm_blinker

Overview:
- Downstream stage of the red-LED PIO output register.
- Consumes the PIO's 18-bit LED level word and drives the physical red LEDs.
- Applies a global PWM brightness and a per-LED blink mask.
- Configured through its own Avalon-MM slave (4 word registers) on the same system bus.

Parameters:
- WIDTH, 18, number of LED channels (matches the PIO output width).
- PWM_DIV, 1, clock cycles per PWM counter step (>=1).
- BLINK_W, 24, width of the blink period register and counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low. Sampled on the rising edge of clk.
- led_in  input  WIDTH  LED level word from the PIO out_port.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, combinational from address.
- led_out  output  WIDTH  registered LED drive.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. Synchronous active-low reset has priority over everything.
- Write condition: chipselect && !write_n. Register updates on the next edge. No wait states.
- Register map (unused readdata bits read 0):
  - 0 CTRL: bit0 pwm_en, bit1 blink_en. Reset 0.
  - 1 DUTY: bits[8:0], value 0..256. Values >256 saturate to 256 on write. Reset 256.
  - 2 PERIOD: bits[BLINK_W-1:0], blink half-period in clocks. Reset 0.
  - 3 MASK: bits[WIDTH-1:0], LEDs subject to blink. Reset 0.
- readdata = the selected register's stored value. DUTY reads back the written value, not the active shadow.
- PWM:
  - Prescaler counts 0..PWM_DIV-1. pwm_cnt (8-bit) increments when the prescaler wraps, and wraps 255->0.
  - duty_act is a shadow of DUTY. It loads only when pwm_cnt==255 and the prescaler wraps, i.e. at a period boundary, so there are no mid-period glitches.
  - pwm_on = (duty_act > pwm_cnt). Duty 0 means always off; 256 means always on.
  - Duty 64 with PWM_DIV=1 gives 64 cycles on out of every 256.
- Blink:
  - PERIOD==0: phase=1 constant, counter held at 0.
  - Otherwise the counter counts 0..PERIOD-1. At PERIOD-1 it clears and phase toggles, so each phase lasts PERIOD clocks.
  - A write to PERIOD clears the counter and sets phase=1 on the same edge.
- Output, registered (1-cycle latency from led_in, CTRL, MASK and pwm/phase state):
  - led_out <= led_in & (pwm_en ? {WIDTH{pwm_on}} : all-ones) & ~(MASK & {WIDTH{blink_en & ~phase}}).
- Reset values:
  - led_out=0, prescaler=0, pwm_cnt=0, duty_act=256.
  - blink counter=0, phase=1.
  - CTRL/DUTY/PERIOD/MASK as listed under the register map.
- Reset asserted mid-period: all counters return to 0 on that edge, and led_out=0 the cycle after.
- Simultaneous DUTY write and period boundary: duty_act loads the old DUTY. The new value takes effect at the following boundary.
- Simultaneous PERIOD write and blink terminal count: the write wins (counter 0, phase 1).
- Write to address with chipselect low: ignored.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks with led_in=0x3FFFF -> led_out=0. Reads return CTRL=0, DUTY=256, PERIOD=0, MASK=0.
- Pass-through: CTRL=0, led_in=0x2A5A5 -> led_out=0x2A5A5 one clock later. Change led_in to 0x15A5A -> follows with 1-cycle latency.
- PWM: PWM_DIV=1, CTRL=1, DUTY=64, led_in=0x3FFFF. After the next boundary, led_out=0x3FFFF for exactly 64 of each 256 cycles and 0 otherwise. DUTY=0 -> always 0. DUTY=300 -> reads 256, always on.
- Glitch-free update: write DUTY=128 mid-period (pwm_cnt=100) -> the current period still shows 64 on-cycles, the next shows 128. Readback returns 128 immediately.
- Blink: CTRL=2, PERIOD=10, MASK=0x00003, led_in=0x3FFFF -> bits[1:0] alternate 10 cycles on / 10 off, bits[17:2] stay 1. Rewriting PERIOD restarts with an on phase.
- Reset mid-operation: PWM and blink active, pulse reset_n low for 1 clock -> led_out=0 the next cycle. Registers return to reset values, and output resumes as plain pass-through.
